// File: rtl/trigger_acq_pkg.sv
// Shared types and constants for the trigger acquisition window controller.
package trigger_acq_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned PRE_AW_DEF     = 8;
    localparam int unsigned CNT_WIDTH_DEF  = 24;
    localparam int unsigned TRIG_CNT_WIDTH = 16;

    // adc_valid to dma_wr: one RAM read stage plus one output register
    localparam int unsigned ACQ_LAT = 2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FILL    = 3'd1;
    localparam logic [2:0] ARMED   = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = IDLE,
        S_FILL    = FILL,
        S_ARMED   = ARMED,
        S_CAPTURE = CAPTURE,
        S_DONE    = DONE
    } acq_state_e;

    // Sideband travelling alongside a window word through the read stage
    typedef struct packed {
        logic wr;
        logic sync;
        logic last;
        logic byp;
    } acq_tag_t;

endpackage

// File: rtl/trigger_acq_delay_ram.sv
// Pre-trigger delay line storage: simple dual-port RAM, registered read, no content reset.
module trigger_acq_delay_ram
    import trigger_acq_pkg::*;
#(
    parameter int unsigned AW = PRE_AW_DEF,
    parameter int unsigned DW = DATA_WIDTH_DEF
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/trigger_acq_ctrl.sv
// Trigger-driven acquisition window controller: pre-trigger delay line plus post-trigger count.
// Optional build macro TRIG_ACQ_RETRIGGER_EN makes DONE transient and re-arms automatically.
module trigger_acq_ctrl
    import trigger_acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PRE_AW     = PRE_AW_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                      adc_clk,
    input  logic                      trig_reset,
    input  logic                      arm,
    input  logic [PRE_AW-1:0]         pre_samples,
    input  logic [CNT_WIDTH-1:0]      post_samples,
    input  logic                      trig_in,
    input  logic [DATA_WIDTH-1:0]     adc_data,
    input  logic                      adc_valid,
    output logic                      dma_wr,
    output logic [DATA_WIDTH-1:0]     dma_data,
    output logic                      dma_sync,
    output logic                      dma_last,
    output logic                      acq_busy,
    output logic                      acq_done,
    output logic [TRIG_CNT_WIDTH-1:0] trig_count
);

    localparam int unsigned RW = CNT_WIDTH + 1;

    acq_state_e                  state_q;
    logic [PRE_AW-1:0]           wr_ptr_q;
    logic [PRE_AW-1:0]           pre_lat_q;
    logic [PRE_AW-1:0]           fill_cnt_q;
    logic [CNT_WIDTH-1:0]        post_lat_q;
    logic [RW-1:0]               remain_q;
    logic                        first_q;
    logic                        trig_d_q;
    acq_tag_t                    s1_q;
    logic [DATA_WIDTH-1:0]       byp_data_q;
    logic [DATA_WIDTH-1:0]       ram_rdata;
    logic                        dma_wr_q;
    logic                        dma_sync_q;
    logic                        dma_last_q;
    logic [DATA_WIDTH-1:0]       dma_data_q;
    logic                        acq_busy_q;
    logic                        acq_done_q;
    logic [TRIG_CNT_WIDTH-1:0]   trig_count_q;

    logic                        trig_edge_c;
    logic                        emit_c;
    logic                        sync_c;
    logic                        last_c;
    logic [RW-1:0]               total_c;
    logic [RW-1:0]               cur_remain_c;
    logic [PRE_AW-1:0]           rd_addr_c;

    trigger_acq_delay_ram #(
        .AW (PRE_AW),
        .DW (DATA_WIDTH)
    ) u_delay_ram (
        .clk_i   (adc_clk),
        .we_i    (adc_valid),
        .waddr_i (wr_ptr_q),
        .wdata_i (adc_data),
        .raddr_i (rd_addr_c),
        .rdata_o (ram_rdata)
    );

    // Window word qualification; the accepting edge cycle already carries the first word
    always_comb begin
        trig_edge_c  = trig_in & ~trig_d_q;
        total_c      = RW'(pre_lat_q) + RW'(post_lat_q);
        cur_remain_c = (state_q == S_ARMED) ? total_c : remain_q;
        emit_c       = adc_valid &
                       (((state_q == S_CAPTURE) & (remain_q != '0)) |
                        ((state_q == S_ARMED) & trig_edge_c));
        sync_c       = emit_c & ((state_q == S_ARMED) | first_q);
        last_c       = emit_c & (cur_remain_c == RW'(1));
        rd_addr_c    = wr_ptr_q - pre_lat_q;
    end

    always_ff @(posedge adc_clk) begin
        if (trig_reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            pre_lat_q    <= '0;
            fill_cnt_q   <= '0;
            post_lat_q   <= '0;
            remain_q     <= '0;
            first_q      <= 1'b0;
            trig_d_q     <= 1'b0;
            s1_q         <= '0;
            byp_data_q   <= '0;
            dma_wr_q     <= 1'b0;
            dma_sync_q   <= 1'b0;
            dma_last_q   <= 1'b0;
            dma_data_q   <= '0;
            acq_busy_q   <= 1'b0;
            acq_done_q   <= 1'b0;
            trig_count_q <= '0;
        end else begin
            trig_d_q <= trig_in;
            if (adc_valid) begin
                wr_ptr_q <= wr_ptr_q + PRE_AW'(1);
            end

            // Bypass path is pipelined to match the RAM read latency
            s1_q       <= '{wr: emit_c, sync: sync_c, last: last_c, byp: (pre_lat_q == '0)};
            byp_data_q <= adc_data;
            dma_wr_q   <= s1_q.wr;
            dma_sync_q <= s1_q.sync;
            dma_last_q <= s1_q.last;
            dma_data_q <= s1_q.wr ? (s1_q.byp ? byp_data_q : ram_rdata) : '0;

            if (emit_c) begin
                remain_q <= cur_remain_c - RW'(1);
                first_q  <= 1'b0;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        pre_lat_q  <= pre_samples;
                        post_lat_q <= (post_samples == '0) ? CNT_WIDTH'(1) : post_samples;
                        fill_cnt_q <= '0;
                        state_q    <= S_FILL;
                        acq_busy_q <= 1'b1;
                        acq_done_q <= 1'b0;
                    end
`ifdef TRIG_ACQ_RETRIGGER_EN
                    else if (state_q == S_DONE) begin
                        state_q    <= S_ARMED;
                        acq_busy_q <= 1'b1;
                        acq_done_q <= 1'b0;
                    end
`endif
                end
                S_FILL: begin
                    if (fill_cnt_q == pre_lat_q) begin
                        state_q <= S_ARMED;
                    end else if (adc_valid) begin
                        fill_cnt_q <= fill_cnt_q + PRE_AW'(1);
                    end
                end
                S_ARMED: begin
                    if (trig_edge_c) begin
                        trig_count_q <= trig_count_q + TRIG_CNT_WIDTH'(1);
                        state_q      <= S_CAPTURE;
                        if (!adc_valid) begin
                            remain_q <= total_c;
                            first_q  <= 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    // Leave once the last word has left the output register
                    if (dma_last_q) begin
                        state_q    <= S_DONE;
                        acq_busy_q <= 1'b0;
                        acq_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dma_wr     = dma_wr_q;
    assign dma_data   = dma_data_q;
    assign dma_sync   = dma_sync_q;
    assign dma_last   = dma_last_q;
    assign acq_busy   = acq_busy_q;
    assign acq_done   = acq_done_q;
    assign trig_count = trig_count_q;

endmodule

// File: tb/tb_trigger_acq_ctrl.sv
// Directed bench for trigger_acq_ctrl; window words collected on the falling edge.
module tb_trigger_acq_ctrl;
    import trigger_acq_pkg::*;

    logic        adc_clk = 1'b0;
    logic        trig_reset = 1'b1;
    logic        arm = 1'b0;
    logic [7:0]  pre_samples = '0;
    logic [23:0] post_samples = '0;
    logic        trig_in = 1'b0;
    logic [63:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        dma_wr;
    logic [63:0] dma_data;
    logic        dma_sync;
    logic        dma_last;
    logic        acq_busy;
    logic        acq_done;
    logic [15:0] trig_count;

    trigger_acq_ctrl dut (
        .adc_clk      (adc_clk),
        .trig_reset   (trig_reset),
        .arm          (arm),
        .pre_samples  (pre_samples),
        .post_samples (post_samples),
        .trig_in      (trig_in),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .dma_wr       (dma_wr),
        .dma_data     (dma_data),
        .dma_sync     (dma_sync),
        .dma_last     (dma_last),
        .acq_busy     (acq_busy),
        .acq_done     (acq_done),
        .trig_count   (trig_count)
    );

    always #5 adc_clk = ~adc_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cnt = 0;
    int idx = 0;
    int vcyc [1024];
    logic [63:0] q_data [$];
    bit          q_sync [$];
    bit          q_last [$];
    int          q_cyc  [$];
    bit done_seen = 1'b0;
    int done_cyc = 0;
    int e;
    int ew [3];
    int nlast;

    always @(posedge adc_clk) cnt <= cnt + 1;

    always @(negedge adc_clk) begin
        if (dma_wr) begin
            q_data.push_back(dma_data);
            q_sync.push_back(dma_sync);
            q_last.push_back(dma_last);
            q_cyc.push_back(cnt);
        end
        if (acq_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cnt;
        end
    end

    function automatic logic [63:0] smp(input int i);
        return {32'(i) ^ 32'hA5A5_0000, 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic t, input logic a);
        adc_valid = v;
        trig_in   = t;
        arm       = a;
        adc_data  = smp(idx);
        if (v) vcyc[idx] = cnt;
        @(posedge adc_clk);
        #1;
        if (v) idx++;
        arm = 1'b0;
    endtask

    task automatic do_reset();
        trig_reset = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        trig_reset = 1'b0;
        q_data.delete();
        q_sync.delete();
        q_last.delete();
        q_cyc.delete();
        done_seen = 1'b0;
    endtask

    // Word j of a window: sample (edge - pre + j), shown ACQ_LAT cycles after valid of sample (edge + j)
    task automatic check_win(input string tag, input int qb, input int n, input int edge_i,
                             input int pre, input bit has_last);
        for (int j = 0; j < n; j++) begin
            if (qb + j >= q_data.size()) begin
                check($sformatf("%s_words", tag), 64'(q_data.size()), 64'(qb + n));
                break;
            end
            check($sformatf("%s_d%0d", tag, j), q_data[qb + j], smp(edge_i - pre + j));
            check($sformatf("%s_lat%0d", tag, j), 64'(q_cyc[qb + j]), 64'(vcyc[edge_i + j] + int'(ACQ_LAT)));
            check($sformatf("%s_sync%0d", tag, j), 64'(q_sync[qb + j]), 64'(j == 0));
            check($sformatf("%s_last%0d", tag, j), 64'(q_last[qb + j]), 64'(has_last && (j == n - 1)));
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_wr", 64'(dma_wr), 64'(0));
        check("rst_data", dma_data, 64'(0));
        check("rst_sync", 64'(dma_sync), 64'(0));
        check("rst_last", 64'(dma_last), 64'(0));
        check("rst_busy", 64'(acq_busy), 64'(0));
        check("rst_done", 64'(acq_done), 64'(0));
        check("rst_tc", 64'(trig_count), 64'(0));

        // Basic window: pre 4, post 8, edge on sample 100
        do_reset();
        idx = 0;
        pre_samples = 8'd4;
        post_samples = 24'd8;
        while (idx < 100) cyc(1'b1, 1'b0, idx == 20);
        check("t1_busy_armed", 64'(acq_busy), 64'(1));
        check("t1_tc_before", 64'(trig_count), 64'(0));
        e = idx;
        cyc(1'b1, 1'b1, 1'b0);
        check("t1_tc_after", 64'(trig_count), 64'(1));
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        check("t1_busy_cap", 64'(acq_busy), 64'(1));
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        check("t1_words", 64'(q_data.size()), 64'(12));
        check_win("t1", 0, 12, e, 4, 1'b1);
        check("t1_tc", 64'(trig_count), 64'(1));
        check("t1_done_seen", 64'(done_seen), 64'(1));
        if (q_cyc.size() == 12) check("t1_done_cyc", 64'(done_cyc), 64'(q_cyc[11] + 1));

        // Zero lengths: one word equal to the edge-cycle sample
        do_reset();
        pre_samples = 8'd0;
        post_samples = 24'd0;
        cyc(1'b1, 1'b0, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        e = idx;
        cyc(1'b1, 1'b1, 1'b0);
        repeat (8) cyc(1'b1, 1'b0, 1'b0);
        check("t2_words", 64'(q_data.size()), 64'(1));
        check_win("t2", 0, 1, e, 0, 1'b1);
        check("t2_tc", 64'(trig_count), 64'(1));

        // Gapped valid 1-of-3: pre 2, post 3
        do_reset();
        pre_samples = 8'd2;
        post_samples = 24'd3;
        cyc(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 18; k++) cyc(k % 3 == 0, 1'b0, 1'b0);
        e = idx;
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 21; k++) cyc(k % 3 == 0, 1'b0, 1'b0);
        check("t3_words", 64'(q_data.size()), 64'(5));
        check_win("t3", 0, 5, e, 2, 1'b1);

        // Edges in FILL and mid-CAPTURE are ignored
        do_reset();
        pre_samples = 8'd3;
        post_samples = 24'd5;
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("t4_tc_fill", 64'(trig_count), 64'(0));
        repeat (6) cyc(1'b1, 1'b0, 1'b0);
        e = idx;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        repeat (15) cyc(1'b1, 1'b0, 1'b0);
        check("t4_words", 64'(q_data.size()), 64'(8));
        check_win("t4", 0, 8, e, 3, 1'b1);
        check("t4_tc", 64'(trig_count), 64'(1));

        // Reset after 3 of 10 words
        do_reset();
        pre_samples = 8'd2;
        post_samples = 24'd8;
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        e = idx;
        cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        trig_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        trig_reset = 1'b0;
        check("t5_wr", 64'(dma_wr), 64'(0));
        check("t5_data", dma_data, 64'(0));
        check("t5_sync", 64'(dma_sync), 64'(0));
        check("t5_last", 64'(dma_last), 64'(0));
        check("t5_busy", 64'(acq_busy), 64'(0));
        check("t5_done", 64'(acq_done), 64'(0));
        check("t5_tc", 64'(trig_count), 64'(0));
        check("t5_words", 64'(q_data.size()), 64'(3));
        check_win("t5", 0, 3, e, 2, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        nlast = 0;
        foreach (q_last[i]) nlast += int'(q_last[i]);
        check("t5_nolast", 64'(nlast), 64'(0));
        check("t5_words_idle", 64'(q_data.size()), 64'(3));
        check("t5_busy_idle", 64'(acq_busy), 64'(0));

        // Three edges 50 samples apart: pre 2, post 4
        do_reset();
        pre_samples = 8'd2;
        post_samples = 24'd4;
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            ew[w] = idx;
            cyc(1'b1, 1'b1, 1'b0);
            repeat (49) cyc(1'b1, 1'b0, 1'b0);
        end
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
`ifdef TRIG_ACQ_RETRIGGER_EN
        check("t6_words", 64'(q_data.size()), 64'(18));
        check("t6_tc", 64'(trig_count), 64'(3));
        for (int w = 0; w < 3; w++) check_win($sformatf("t6w%0d", w), 6 * w, 6, ew[w], 2, 1'b1);
`else
        check("t6_words", 64'(q_data.size()), 64'(6));
        check("t6_tc", 64'(trig_count), 64'(1));
        check_win("t6w0", 0, 6, ew[0], 2, 1'b1);
        check("t6_done", 64'(acq_done), 64'(1));
        check("t6_busy", 64'(acq_busy), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
